// File: rtl/rtc_update_sequencer.sv
// rtc_update_sequencer
// Owns the shared databus of the clock/calendar register bank. On every 1 Hz tick it
// performs a read-increment-write of the seconds field and ripples the carry through
// min, hour, day, date, month and year. Date limits follow the live month and the leap
// rule. The bus is also lent to the timer-set controller through a req/gnt handshake.
// Every field costs three cycles (RD, CALC, WR). All outputs are registered.

module rtc_update_sequencer #(
    parameter int DATA_W     = 6,
    parameter int HOUR_MAX   = 23,
    parameter int YEAR_MAX   = 63,
    parameter int LEAP_PHASE = 0
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              tick_1hz,
    input  logic [DATA_W-1:0] bus_rd,
    input  logic [3:0]        cur_month,
    input  logic [DATA_W-1:0] cur_year,
    input  logic              set_req,
    output logic              set_gnt,
    output logic [6:0]        field_sel,
    output logic              rd_en,
    output logic              wr_en,
    output logic [DATA_W-1:0] bus_wr,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    typedef enum logic [2:0] {IDLE, GRANT, RD, CALC, WR} state_t;

    // Field index doubles as the bit position in field_sel
    localparam logic [2:0] F_SEC   = 3'd0;
    localparam logic [2:0] F_MIN   = 3'd1;
    localparam logic [2:0] F_HOUR  = 3'd2;
    localparam logic [2:0] F_DAY   = 3'd3;
    localparam logic [2:0] F_DATE  = 3'd4;
    localparam logic [2:0] F_MONTH = 3'd5;
    localparam logic [2:0] F_YEAR  = 3'd6;

    state_t            state_q;
    logic [2:0]        field_q;
    logic              tick_pend_q;
    logic              carry_q;
    logic              set_gnt_q;
    logic [6:0]        field_sel_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] bus_wr_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;

    logic [DATA_W-1:0] dim;
    logic              leap;
    logic [DATA_W-1:0] fieldMin;
    logic [DATA_W-1:0] fieldMax;
    logic [DATA_W-1:0] nv_d;
    logic              carry_d;
    logic              moreFields;
    logic [2:0]        nextField;

    // Days in the live month; unknown month codes fall back to 31
    always_comb begin
        leap = ((cur_year & DATA_W'(3)) == DATA_W'(LEAP_PHASE));
        case (cur_month)
            4'd2:                      dim = leap ? DATA_W'(29) : DATA_W'(28);
            4'd4, 4'd6, 4'd9, 4'd11:   dim = DATA_W'(30);
            default:                   dim = DATA_W'(31);
        endcase
    end

    // Wrap limits of the field being worked on, and its incremented value
    always_comb begin
        fieldMin = '0;
        fieldMax = DATA_W'(59);
        case (field_q)
            F_SEC, F_MIN: fieldMax = DATA_W'(59);
            F_HOUR:       fieldMax = DATA_W'(HOUR_MAX);
            F_DAY:        fieldMax = DATA_W'(6);
            F_DATE: begin
                fieldMin = DATA_W'(1);
                fieldMax = dim;
            end
            F_MONTH: begin
                fieldMin = DATA_W'(1);
                fieldMax = DATA_W'(12);
            end
            default:      fieldMax = DATA_W'(YEAR_MAX);
        endcase
        carry_d = (bus_rd >= fieldMax);
        nv_d    = carry_d ? fieldMin : bus_rd + DATA_W'(1);
    end

    // The day field always hands over to date; year carry is dropped
    always_comb begin
        nextField  = field_q + 3'd1;
        moreFields = (carry_q || (field_q == F_DAY)) && (field_q != F_YEAR);
    end

    // Sequencer state, tick bookkeeping and registered bus controls
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            field_q     <= F_SEC;
            tick_pend_q <= 1'b0;
            carry_q     <= 1'b0;
            set_gnt_q   <= 1'b0;
            field_sel_q <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            bus_wr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if ((state_q == IDLE) && tick_pend_q) begin
                tick_pend_q <= tick_1hz;
            end else if (tick_1hz) begin
                if (tick_pend_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    tick_pend_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (tick_pend_q) begin
                        state_q     <= RD;
                        field_q     <= F_SEC;
                        field_sel_q <= 7'b1;
                        rd_en_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (set_req) begin
                        state_q   <= GRANT;
                        set_gnt_q <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!set_req) begin
                        state_q   <= IDLE;
                        set_gnt_q <= 1'b0;
                    end
                end
                RD: begin
                    state_q     <= CALC;
                    rd_en_q     <= 1'b0;
                    field_sel_q <= '0;
                end
                CALC: begin
                    state_q     <= WR;
                    carry_q     <= carry_d;
                    bus_wr_q    <= nv_d;
                    wr_en_q     <= 1'b1;
                    field_sel_q <= 7'b1 << field_q;
                end
                WR: begin
                    wr_en_q  <= 1'b0;
                    bus_wr_q <= '0;
                    if (moreFields) begin
                        state_q     <= RD;
                        field_q     <= nextField;
                        field_sel_q <= 7'b1 << nextField;
                        rd_en_q     <= 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        field_sel_q <= '0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign set_gnt   = set_gnt_q;
    assign field_sel = field_sel_q;
    assign rd_en     = rd_en_q;
    assign wr_en     = wr_en_q;
    assign bus_wr    = bus_wr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rtc_update_sequencer.sv
// tb_rtc_update_sequencer
// Drives rtc_update_sequencer against a small register-bank model and compares every
// write it makes with a calendar reference computed from the bank contents.

module tb_rtc_update_sequencer;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       tick_1hz;
    logic [5:0] bus_rd;
    logic [3:0] cur_month;
    logic [5:0] cur_year;
    logic       set_req;
    logic       set_gnt;
    logic [6:0] field_sel;
    logic       rd_en;
    logic       wr_en;
    logic [5:0] bus_wr;
    logic       busy;
    logic       done;
    logic       overrun;

    rtc_update_sequencer dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .tick_1hz  (tick_1hz),
        .bus_rd    (bus_rd),
        .cur_month (cur_month),
        .cur_year  (cur_year),
        .set_req   (set_req),
        .set_gnt   (set_gnt),
        .field_sel (field_sel),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .bus_wr    (bus_wr),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failures = 0;

    // Register bank contents: sec, min, hour, day, date, month, year
    logic [5:0] bank [7];
    int model [7];
    int wrIdx [$];
    int wrVal [$];
    int expIdx [$];
    int expVal [$];
    int busyCnt;
    int doneCnt;
    int clashCnt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int daysInMonth(input int m, input int y);
        case (m)
            2:            return (y % 4 == 0) ? 29 : 28;
            4, 6, 9, 11:  return 30;
            default:      return 31;
        endcase
    endfunction

    // Counting field: one past the top (or anything above) rolls to the bottom with a carry
    function automatic int bump(input int x, input int lo, input int hi, output bit wrapped);
        if (x < hi) begin
            wrapped = 1'b0;
            return x + 1;
        end
        wrapped = 1'b1;
        return lo;
    endfunction

    task automatic pushExp(input int f);
        expIdx.push_back(f);
        expVal.push_back(model[f]);
    endtask

    // One second of calendar time applied to the model, logging each field it rewrites
    task automatic modelStep();
        bit c;
        model[0] = bump(model[0], 0, 59, c); pushExp(0); if (!c) return;
        model[1] = bump(model[1], 0, 59, c); pushExp(1); if (!c) return;
        model[2] = bump(model[2], 0, 23, c); pushExp(2); if (!c) return;
        model[3] = bump(model[3], 0, 6, c);  pushExp(3);
        model[4] = bump(model[4], 1, daysInMonth(model[5], model[6]), c); pushExp(4); if (!c) return;
        model[5] = bump(model[5], 1, 12, c); pushExp(5); if (!c) return;
        model[6] = bump(model[6], 0, 63, c); pushExp(6);
    endtask

    task automatic modelFromBank();
        expIdx.delete();
        expVal.delete();
        for (int f = 0; f < 7; f++) model[f] = int'(bank[f]);
    endtask

    task automatic setBank(input int s, input int mi, input int h, input int d,
                           input int dt, input int mo, input int y);
        bank[0] = 6'(s);  bank[1] = 6'(mi); bank[2] = 6'(h); bank[3] = 6'(d);
        bank[4] = 6'(dt); bank[5] = 6'(mo); bank[6] = 6'(y);
        cur_month = bank[5][3:0];
        cur_year  = bank[6];
    endtask

    task automatic clearRecord();
        wrIdx.delete();
        wrVal.delete();
        busyCnt = 0;
        doneCnt = 0;
    endtask

    // Bank side of the bus, evaluated mid-cycle from the registered DUT controls
    task automatic serviceBank();
        int idx = -1;
        int hot = 0;
        for (int f = 0; f < 7; f++) if (field_sel[f]) begin idx = f; hot++; end
        if (busy) busyCnt++;
        if (done) doneCnt++;
        if (set_gnt && (rd_en || wr_en)) clashCnt++;
        if (rd_en && wr_en) clashCnt++;
        if ((rd_en || wr_en) && hot != 1) clashCnt++;
        if (!(rd_en || wr_en) && field_sel != 7'd0) clashCnt++;
        if (rd_en && idx >= 0) bus_rd = bank[idx];
        if (wr_en && idx >= 0) begin
            wrIdx.push_back(idx);
            wrVal.push_back(int'(bus_wr));
            bank[idx] = bus_wr;
        end
        cur_month = bank[5][3:0];
        cur_year  = bank[6];
    endtask

    task automatic applyStimulus(input bit tick, input bit req);
        @(negedge clk);
        serviceBank();
        tick_1hz = tick;
        set_req  = req;
    endtask

    task automatic waitDone(input int want, input string tag);
        for (int i = 0; i < 120 && doneCnt < want; i++) applyStimulus(1'b0, 1'b0);
        checkOutput({tag, " done count"}, doneCnt, want);
    endtask

    task automatic compareRecord(input string tag, input int wantDone);
        checkOutput({tag, " write count"}, wrIdx.size(), expIdx.size());
        for (int i = 0; i < wrIdx.size() && i < expIdx.size(); i++) begin
            checkOutput($sformatf("%s write%0d field", tag, i), wrIdx[i], expIdx[i]);
            checkOutput($sformatf("%s write%0d value", tag, i), wrVal[i], expVal[i]);
        end
        checkOutput({tag, " busy cycles"}, busyCnt, 3 * expIdx.size());
        checkOutput({tag, " done pulses"}, doneCnt, wantDone);
    endtask

    task automatic runUpdate(input string tag);
        modelFromBank();
        modelStep();
        clearRecord();
        applyStimulus(1'b1, 1'b0);
        waitDone(1, tag);
        compareRecord(tag, 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " set_gnt"}, set_gnt, 0);
        checkOutput({tag, " field_sel"}, field_sel, 0);
        checkOutput({tag, " rd_en"}, rd_en, 0);
        checkOutput({tag, " wr_en"}, wr_en, 0);
        checkOutput({tag, " bus_wr"}, bus_wr, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " overrun"}, overrun, 0);
    endtask

    initial begin
        int s, mi, h, d, dt, mo, y;

        clear_n  = 1'b0;
        tick_1hz = 1'b0;
        set_req  = 1'b0;
        bus_rd   = '0;
        setBank(0, 0, 0, 0, 1, 1, 0);
        clearRecord();
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        clear_n = 1'b1;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("idle busy", busy, 0);

        // T1: seconds-only update, cycle by cycle
        setBank(12, 30, 10, 3, 15, 6, 20);
        clearRecord();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("T1 pend busy", busy, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("T1 rd_en", rd_en, 1);
        checkOutput("T1 rd field_sel", field_sel, 7'b0000001);
        checkOutput("T1 rd busy", busy, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("T1 calc rd_en", rd_en, 0);
        checkOutput("T1 calc field_sel", field_sel, 0);
        checkOutput("T1 calc busy", busy, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("T1 wr_en", wr_en, 1);
        checkOutput("T1 bus_wr", bus_wr, 13);
        checkOutput("T1 wr field_sel", field_sel, 7'b0000001);
        applyStimulus(1'b0, 1'b0);
        checkOutput("T1 done", done, 1);
        checkOutput("T1 end busy", busy, 0);
        checkOutput("T1 end wr_en", wr_en, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("T1 done width", done, 0);
        checkOutput("T1 busy cycles", busyCnt, 3);
        checkOutput("T1 sec", bank[0], 13);
        checkOutput("T1 min untouched", bank[1], 30);

        // T2: full rollover through every field
        setBank(59, 59, 23, 6, 31, 12, 5);
        runUpdate("T2");
        checkOutput("T2 busy 21", busyCnt, 21);
        checkOutput("T2 date", bank[4], 1);
        checkOutput("T2 month", bank[5], 1);
        checkOutput("T2 year", bank[6], 6);

        // T3: February end in leap and non-leap years
        setBank(59, 59, 23, 4, 28, 2, 8);
        runUpdate("T3 leap");
        checkOutput("T3 leap date", bank[4], 29);
        checkOutput("T3 leap month", bank[5], 2);
        setBank(59, 59, 23, 4, 28, 2, 9);
        runUpdate("T3 plain");
        checkOutput("T3 plain date", bank[4], 1);
        checkOutput("T3 plain month", bank[5], 3);

        // Out-of-range seconds wrap like 59
        setBank(63, 7, 1, 1, 1, 1, 1);
        runUpdate("oor sec");
        checkOutput("oor min", bank[1], 8);

        // T4: timer-set grant holds off a tick until set_req drops
        setBank(20, 1, 1, 1, 1, 1, 1);
        modelFromBank();
        modelStep();
        clearRecord();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("T4 gnt", set_gnt, 1);
        checkOutput("T4 gnt rd_en", rd_en, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("T4 hold gnt", set_gnt, 1);
        checkOutput("T4 hold busy", busy, 0);
        checkOutput("T4 hold field_sel", field_sel, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("T4 still gnt", set_gnt, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("T4 gnt drop", set_gnt, 0);
        checkOutput("T4 no rd yet", rd_en, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("T4 rd starts", rd_en, 1);
        checkOutput("T4 rd sec", field_sel, 7'b0000001);
        waitDone(1, "T4");
        compareRecord("T4", 1);

        // T5: two extra ticks during a long rollover
        setBank(59, 59, 23, 6, 31, 12, 5);
        modelFromBank();
        modelStep();
        modelStep();
        clearRecord();
        applyStimulus(1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitDone(2, "T5");
        repeat (10) applyStimulus(1'b0, 1'b0);
        compareRecord("T5", 2);
        checkOutput("T5 overrun", overrun, 1);
        checkOutput("T5 sec", bank[0], 1);

        // T6: reset lands in the CALC cycle of the minutes field
        setBank(59, 10, 3, 2, 15, 6, 20);
        clearRecord();
        applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0);
        checkOutput("T6 in calc busy", busy, 1);
        checkOutput("T6 in calc rd_en", rd_en, 0);
        checkOutput("T6 writes before", wrIdx.size(), 1);
        tick_1hz = 1'b0;
        clear_n = 1'b0;
        #1;
        checkAllZero("T6 reset");
        #2;
        clear_n = 1'b1;
        clearRecord();
        repeat (10) applyStimulus(1'b0, 1'b0);
        checkOutput("T6 no pend busy", busyCnt, 0);
        checkOutput("T6 no writes", wrIdx.size(), 0);
        checkOutput("T6 sec kept", bank[0], 0);
        checkOutput("T6 min kept", bank[1], 10);

        // Randomised calendar states, biased toward field maxima
        for (int t = 0; t < 30; t++) begin
            s  = ($urandom_range(1) == 1) ? 59 : int'($urandom_range(58));
            if ($urandom_range(7) == 0) s = 60 + int'($urandom_range(3));
            mi = ($urandom_range(1) == 1) ? 59 : int'($urandom_range(58));
            h  = ($urandom_range(1) == 1) ? 23 : int'($urandom_range(22));
            d  = ($urandom_range(1) == 1) ? 6 : int'($urandom_range(5));
            mo = int'($urandom_range(12, 1));
            y  = ($urandom_range(2) == 0) ? 63 : int'($urandom_range(62));
            dt = ($urandom_range(1) == 1) ? daysInMonth(mo, y) : int'($urandom_range(31, 1));
            setBank(s, mi, h, d, dt, mo, y);
            repeat ($urandom_range(2)) applyStimulus(1'b0, 1'b0);
            runUpdate($sformatf("rand%0d", t));
        end

        checkOutput("bus exclusivity", clashCnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
